// File: rtl/alu_multibyte_seq.sv
// ---------------------------------------------------------------------------
// alu_multibyte_seq
//   Sequencer that runs NBYTES-wide ADD / SHL / SHR / CEQ operations on an
//   external 8-bit combinational ALU, one byte per clock. It feeds the ALU's
//   overflow output back into its overflow input on the next byte, so the
//   carry (ADD) or the shifted-out bit (SHL/SHR) passes from byte to byte.
//   For CEQ, the ALU's per-byte equality flag is AND-reduced across bytes.
//
// Ports
//   i_clk, i_reset        clock (rising edge); synchronous active-high reset
//   i_start, i_cmd        request and command (00 ADD, 01 SHL, 10 SHR, 11 CEQ)
//   i_a_in, i_b_in, i_cin operands and carry/shift-in, latched on accept
//   o_busy, o_done        running indicator; one-cycle completion pulse
//   o_result, o_flag,     W-bit result, CEQ flag, final carry/shift-out
//   o_overflow
//   o_alu_*               drive the ALU INPUTA/INPUTB/OP/FUNC/FLAG_IN/OVERFLOW_IN
//   i_alu_*               return path from the ALU OUT/FLAG_OUT/OVERFLOW_OUT
//
// State  | meaning
// -------+----------------------------------------------------------------
// IDLE   | waiting for i_start; ALU inputs parked at zero/ADD
// RUN    | one byte per cycle, byte index k = 0..NBYTES-1
// DONE   | o_done high for one cycle, results valid; back to IDLE
// ---------------------------------------------------------------------------
module alu_multibyte_seq #(
  parameter int         NBYTES      = 2,
  parameter logic [2:0] OP_OTYPE    = 3'b111,
  parameter logic [2:0] OP_ADD      = 3'b000,
  parameter logic [2:0] OP_CEQ      = 3'b100,
  parameter logic [2:0] FN_SHIFTL_O = 3'b001,
  parameter logic [2:0] FN_SHIFTR_O = 3'b010
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_start,
  input  logic [1:0]          i_cmd,
  input  logic [8*NBYTES-1:0] i_a_in,
  input  logic [8*NBYTES-1:0] i_b_in,
  input  logic                i_cin,
  output logic                o_busy,
  output logic                o_done,
  output logic [8*NBYTES-1:0] o_result,
  output logic                o_flag,
  output logic                o_overflow,
  output logic [7:0]          o_alu_a,
  output logic [7:0]          o_alu_b,
  output logic [2:0]          o_alu_op,
  output logic [2:0]          o_alu_func,
  output logic                o_alu_flag_in,
  output logic                o_alu_ovf_in,
  input  logic [7:0]          i_alu_out,
  input  logic                i_alu_flag_out,
  input  logic                i_alu_ovf_out
);

  localparam int W  = 8 * NBYTES;
  localparam int KW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [KW-1:0] LAST_K = KW'(NBYTES - 1);

  localparam logic [1:0] CMD_ADD = 2'b00;
  localparam logic [1:0] CMD_SHL = 2'b01;
  localparam logic [1:0] CMD_SHR = 2'b10;
  localparam logic [1:0] CMD_CEQ = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_t;

  state_t          r_state;
  logic [1:0]      r_cmd;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic            r_chain;
  logic            r_flag_acc;
  logic [KW-1:0]   r_k;
  logic            r_busy;
  logic            r_done;
  logic [W-1:0]    r_result;
  logic            r_flag;
  logic            r_overflow;

  logic [KW-1:0]   w_byte;
  logic [7:0]      w_a_byte;
  logic [7:0]      w_b_byte;
  logic            w_run;

  assign w_run = (r_state == S_RUN);

  // SHR walks from the top byte down so the shift-in bit enters at the MSB.
  always_comb begin
    w_byte = r_k;
    if (r_cmd == CMD_SHR) begin
      w_byte = LAST_K - r_k;
    end
  end

  always_comb begin
    w_a_byte = 8'h00;
    w_b_byte = 8'h00;
    for (int i = 0; i < NBYTES; i++) begin
      if (w_byte == KW'(i)) begin
        w_a_byte = r_a[i*8 +: 8];
        w_b_byte = r_b[i*8 +: 8];
      end
    end
  end

  // ALU drive; parked at ADD with zero operands outside RUN.
  always_comb begin
    o_alu_a      = 8'h00;
    o_alu_b      = 8'h00;
    o_alu_op     = OP_ADD;
    o_alu_func   = 3'b000;
    o_alu_ovf_in = 1'b0;
    if (w_run) begin
      o_alu_ovf_in = r_chain;
      case (r_cmd)
        CMD_ADD: begin
          o_alu_op = OP_ADD;
          o_alu_a  = w_a_byte;
          o_alu_b  = w_b_byte;
        end
        CMD_SHL: begin
          o_alu_op   = OP_OTYPE;
          o_alu_func = FN_SHIFTL_O;
          o_alu_a    = w_a_byte;
        end
        CMD_SHR: begin
          o_alu_op   = OP_OTYPE;
          o_alu_func = FN_SHIFTR_O;
          o_alu_a    = w_a_byte;
        end
        default: begin
          o_alu_op = OP_CEQ;
          o_alu_a  = w_a_byte;
          o_alu_b  = w_b_byte;
        end
      endcase
    end
  end

  assign o_alu_flag_in = r_flag;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_cmd      <= CMD_ADD;
      r_a        <= '0;
      r_b        <= '0;
      r_chain    <= 1'b0;
      r_flag_acc <= 1'b0;
      r_k        <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_result   <= '0;
      r_flag     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (i_start) begin
            r_cmd      <= i_cmd;
            r_a        <= i_a_in;
            r_b        <= i_b_in;
            r_chain    <= i_cin;
            r_flag_acc <= 1'b1;
            r_k        <= '0;
            r_busy     <= 1'b1;
            r_state    <= S_RUN;
          end
        end

        S_RUN: begin
          for (int i = 0; i < NBYTES; i++) begin
            if (w_byte == KW'(i)) begin
              r_result[i*8 +: 8] <= i_alu_out;
            end
          end
          r_chain <= i_alu_ovf_out;
          if (r_cmd == CMD_CEQ) begin
            r_flag_acc <= r_flag_acc & i_alu_flag_out;
          end
          if (r_k == LAST_K) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
            if (r_cmd == CMD_CEQ) begin
              r_flag     <= r_flag_acc & i_alu_flag_out;
              r_overflow <= 1'b0;
            end else begin
              r_overflow <= i_alu_ovf_out;
            end
          end else begin
            r_k <= r_k + 1'b1;
          end
        end

        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_result   = r_result;
  assign o_flag     = r_flag;
  assign o_overflow = r_overflow;

endmodule

// File: tb/tb_alu_multibyte_seq.sv
module tb_alu_multibyte_seq;

  localparam int NB = 2;
  localparam int W  = 16;
  localparam logic [2:0] OP_OTYPE = 3'b111;
  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_CEQ   = 3'b100;
  localparam logic [2:0] FN_L     = 3'b001;
  localparam logic [2:0] FN_R     = 3'b010;

  logic         clk;
  logic         i_reset;
  logic         i_start;
  logic [1:0]   i_cmd;
  logic [W-1:0] i_a_in;
  logic [W-1:0] i_b_in;
  logic         i_cin;
  logic         o_busy;
  logic         o_done;
  logic [W-1:0] o_result;
  logic         o_flag;
  logic         o_overflow;
  logic [7:0]   alu_a;
  logic [7:0]   alu_b;
  logic [2:0]   alu_op;
  logic [2:0]   alu_func;
  logic         alu_flag_in;
  logic         alu_ovf_in;
  logic [7:0]   alu_out;
  logic         alu_fo;
  logic         alu_vo;

  int total = 0;
  int bad   = 0;
  bit chk_en = 0;

  alu_multibyte_seq #(
    .NBYTES(NB), .OP_OTYPE(OP_OTYPE), .OP_ADD(OP_ADD), .OP_CEQ(OP_CEQ),
    .FN_SHIFTL_O(FN_L), .FN_SHIFTR_O(FN_R)
  ) dut (
    .i_clk(clk), .i_reset(i_reset), .i_start(i_start), .i_cmd(i_cmd),
    .i_a_in(i_a_in), .i_b_in(i_b_in), .i_cin(i_cin),
    .o_busy(o_busy), .o_done(o_done), .o_result(o_result), .o_flag(o_flag),
    .o_overflow(o_overflow), .o_alu_a(alu_a), .o_alu_b(alu_b),
    .o_alu_op(alu_op), .o_alu_func(alu_func), .o_alu_flag_in(alu_flag_in),
    .o_alu_ovf_in(alu_ovf_in), .i_alu_out(alu_out),
    .i_alu_flag_out(alu_fo), .i_alu_ovf_out(alu_vo)
  );

  // 8-bit ALU stand-in
  always_comb begin
    alu_out = 8'h00;
    alu_fo  = 1'b0;
    alu_vo  = 1'b0;
    case (alu_op)
      OP_ADD:   {alu_vo, alu_out} = {1'b0, alu_a} + {1'b0, alu_b} + {8'h00, alu_ovf_in};
      OP_CEQ:   alu_fo = (alu_a == alu_b);
      OP_OTYPE: begin
        if (alu_func == FN_L)      {alu_vo, alu_out} = {alu_a, alu_ovf_in};
        else if (alu_func == FN_R) {alu_out, alu_vo} = {alu_ovf_in, alu_a};
      end
      default: ;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Behavioural model: operation-level arithmetic plus a cycle count since accept.
  int           since = -1;
  logic [W-1:0] m_res;
  logic         m_flag;
  logic         m_ovf;
  logic [W-1:0] p_res;
  logic         p_flag;
  logic         p_ovf;
  logic         p_ceq;

  initial begin
    m_res = '0; m_flag = 1'b0; m_ovf = 1'b0;
    p_res = '0; p_flag = 1'b0; p_ovf = 1'b0; p_ceq = 1'b0;
    forever begin
      @(posedge clk);
      if (i_reset) begin
        since = -1;
        m_res = '0; m_flag = 1'b0; m_ovf = 1'b0;
      end else if ((since < 0 || since > NB) && i_start) begin
        since = 0;
        p_ceq = 1'b0;
        case (i_cmd)
          2'b00: {p_ovf, p_res} = {1'b0, i_a_in} + {1'b0, i_b_in} + {16'h0, i_cin};
          2'b01: {p_ovf, p_res} = {i_a_in, i_cin};
          2'b10: {p_res, p_ovf} = {i_cin, i_a_in};
          default: begin
            p_res  = '0;
            p_ovf  = 1'b0;
            p_flag = (i_a_in == i_b_in);
            p_ceq  = 1'b1;
          end
        endcase
      end else if (since >= 0 && since <= NB) begin
        since++;
        if (since == NB) begin
          m_res = p_res;
          m_ovf = p_ovf;
          if (p_ceq) m_flag = p_flag;
        end
      end
    end
  end

  // Per-cycle compare against the model
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("busy", {31'b0, o_busy}, {31'b0, (since >= 0 && since < NB)});
        check("done", {31'b0, o_done}, {31'b0, (since == NB)});
        if (!(since >= 0 && since < NB)) begin
          check("result", {16'b0, o_result}, {16'b0, m_res});
          check("flag", {31'b0, o_flag}, {31'b0, m_flag});
          check("overflow", {31'b0, o_overflow}, {31'b0, m_ovf});
          check("alu_a_idle", {24'b0, alu_a}, 32'h0);
          check("alu_ovf_in_idle", {31'b0, alu_ovf_in}, 32'h0);
          check("alu_op_idle", {29'b0, alu_op}, {29'b0, OP_ADD});
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_op(input string nm, input logic [1:0] cmd, input logic [15:0] a,
                       input logic [15:0] b, input logic cin, input logic [15:0] er,
                       input logic eo, input logic ef);
    int n;
    int nbusy;
    i_cmd = cmd; i_a_in = a; i_b_in = b; i_cin = cin; i_start = 1'b1;
    step();
    i_start = 1'b0;
    n = 0;
    nbusy = o_busy ? 1 : 0;
    while (!o_done && n < 12) begin
      step();
      n++;
      if (o_busy) nbusy++;
    end
    if (!o_done) begin
      total++; bad++;
      $display("FAIL %s_timeout actual=no_done required=done", nm);
    end else begin
      check({nm, "_res"}, {16'b0, o_result}, {16'b0, er});
      check({nm, "_ovf"}, {31'b0, o_overflow}, {31'b0, eo});
      check({nm, "_flag"}, {31'b0, o_flag}, {31'b0, ef});
      check({nm, "_busy_cycles"}, nbusy, 2);
    end
    step();
  endtask

  initial begin
    int nd;
    i_reset = 1'b1; i_start = 1'b0; i_cmd = 2'b00;
    i_a_in = '0; i_b_in = '0; i_cin = 1'b0;
    step();
    step();
    i_reset = 1'b0;
    chk_en = 1'b1;
    check("rst_busy", {31'b0, o_busy}, 32'h0);
    check("rst_done", {31'b0, o_done}, 32'h0);
    check("rst_result", {16'b0, o_result}, 32'h0);
    check("rst_flag", {31'b0, o_flag}, 32'h0);
    check("rst_ovf", {31'b0, o_overflow}, 32'h0);
    step();

    do_op("add1", 2'b00, 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0);
    do_op("add2", 2'b00, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    do_op("add3", 2'b00, 16'h1234, 16'h0000, 1'b1, 16'h1235, 1'b0, 1'b0);
    do_op("shl",  2'b01, 16'h80C0, 16'hFFFF, 1'b1, 16'h0181, 1'b1, 1'b0);
    do_op("shr",  2'b10, 16'h0103, 16'hFFFF, 1'b0, 16'h0081, 1'b1, 1'b0);
    do_op("shl0", 2'b01, 16'h4001, 16'h0000, 1'b0, 16'h8002, 1'b0, 1'b0);
    do_op("shr1", 2'b10, 16'h0002, 16'h0000, 1'b1, 16'h8001, 1'b0, 1'b0);
    do_op("ceq1", 2'b11, 16'hABCD, 16'hABCD, 1'b1, 16'h0000, 1'b0, 1'b1);
    do_op("addk", 2'b00, 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b1);
    do_op("ceq2", 2'b11, 16'hABCD, 16'hAB00, 1'b0, 16'h0000, 1'b0, 1'b0);
    do_op("ceq3", 2'b11, 16'h00CD, 16'hABCD, 1'b0, 16'h0000, 1'b0, 1'b0);
    do_op("ceq4", 2'b11, 16'h5A5A, 16'h5A5A, 1'b0, 16'h0000, 1'b0, 1'b1);

    // START held through RUN: only one operation, one DONE pulse
    i_cmd = 2'b00; i_a_in = 16'h0F0F; i_b_in = 16'h0101; i_cin = 1'b0; i_start = 1'b1;
    step();
    step();
    i_a_in = 16'h7777;
    step();
    i_start = 1'b0;
    nd = o_done ? 1 : 0;
    repeat (6) begin
      step();
      if (o_done) nd++;
    end
    check("ignore_start_dones", nd, 1);
    check("ignore_start_res", {16'b0, o_result}, 32'h1010);

    // RESET in the middle of RUN
    i_cmd = 2'b00; i_a_in = 16'h00FF; i_b_in = 16'h0001; i_cin = 1'b0; i_start = 1'b1;
    step();
    i_start = 1'b0;
    i_reset = 1'b1;
    step();
    i_reset = 1'b0;
    check("midrst_busy", {31'b0, o_busy}, 32'h0);
    check("midrst_result", {16'b0, o_result}, 32'h0);
    check("midrst_flag", {31'b0, o_flag}, 32'h0);
    check("midrst_ovf", {31'b0, o_overflow}, 32'h0);
    nd = o_done ? 1 : 0;
    repeat (4) begin
      step();
      if (o_done) nd++;
    end
    check("midrst_no_done", nd, 0);

    // RESET and START together: START dropped
    i_cmd = 2'b00; i_a_in = 16'h0001; i_b_in = 16'h0001; i_start = 1'b1; i_reset = 1'b1;
    step();
    i_start = 1'b0; i_reset = 1'b0;
    check("rststart_busy", {31'b0, o_busy}, 32'h0);
    step();
    check("rststart_busy2", {31'b0, o_busy}, 32'h0);

    do_op("fresh", 2'b00, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b0);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
